// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: ctrl bit indices,
// opcodes, FSM state encoding and the NOP instruction word.
// Pure declarations; no logic, no latency, no flow control.
package hazard_ctrl_pkg;

  // Bit positions in the 8-bit ctrl word {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump}
  localparam int CTRL_JUMP     = 0;
  localparam int CTRL_BRANCH   = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_REGWRITE = 4;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_ALUSRC   = 6;
  localparam int CTRL_REGDST   = 7;

  // Opcodes that matter for the rt-source check
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hz_state_t;

  // True when the instruction reads rt as a source register
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare: EX-stage load destination (rt) against ID-stage sources.
// Latency: purely combinational, same cycle.
// Backpressure: none; the result feeds the stall decision in hazard_ctrl.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic       mem_read_ex,
  input  logic [4:0] rt_ex,
  input  logic [5:0] op_id,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  output logic       lu_hit
);

  // A load into $0 never creates a dependency; rt only counts for rt-reading opcodes
  always_comb begin
    lu_hit = mem_read_ex && (rt_ex != 5'd0) &&
             ((rt_ex == rs_id) || ((rt_ex == rt_id) && reads_rt(op_id)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush, PC/IF/ID/ID-EX control.
// Latency: outputs combinational from state and inputs; stall lasts LU_STALL_CYCLES cycles.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX. Optional stats via HAZARD_STATS_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LU_STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_ID,
  input  logic [31:0] inst_EX,
  input  logic [7:0]  ctrl_EX,
  input  logic        branch_taken_EX,
  input  logic        jump_ID,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  hz_state_t  state;
  logic [2:0] scnt;
  logic       lu_hit;
  logic       do_branch;
  logic       do_stall;
  logic       do_jump;
  logic       unused_bits;

  hazard_detect u_detect (
    .mem_read_ex (ctrl_EX[CTRL_MEMREAD]),
    .rt_ex       (inst_EX[20:16]),
    .op_id       (inst_ID[31:26]),
    .rs_id       (inst_ID[25:21]),
    .rt_id       (inst_ID[20:16]),
    .lu_hit      (lu_hit)
  );

  assign unused_bits = ^{inst_ID[15:0], inst_EX[31:21], inst_EX[15:0], ctrl_EX[7:4], ctrl_EX[2:0]};

  // Priority decode: branch beats stall beats jump; lu_hit only matters in RUN
  always_comb begin
    do_branch = branch_taken_EX;
    do_stall  = !do_branch && ((state == ST_STALL) || lu_hit);
    do_jump   = !do_branch && !do_stall && jump_ID;
  end

  // Output pattern; reset overrides everything so the pipe holds a bubble while rst_n is low
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (do_branch) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (do_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (do_jump) begin
      ifid_flush  = 1'b1;
    end
  end

  // Stall FSM: a single-cycle stall needs no extra state since the bubble clears MemRead in EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      scnt  <= 3'd0;
    end else if (do_branch) begin
      state <= ST_RUN;
      scnt  <= 3'd0;
    end else if (state == ST_STALL) begin
      scnt <= scnt - 3'd1;
      if (scnt == 3'd1) begin
        state <= ST_RUN;
      end
    end else if (lu_hit && (LU_STALL_CYCLES > 1)) begin
      state <= ST_STALL;
      scnt  <= 3'(LU_STALL_CYCLES - 1);
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating event counters for stall cycles and flush cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (do_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if ((do_branch || do_jump) && (flush_cnt != 32'hFFFF_FFFF)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`else
  // Stats disabled: counters read as zero
  always_comb begin
    stall_cnt = 32'd0;
    flush_cnt = 32'd0;
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with LU_STALL_CYCLES=1 and =3 instances.
// Inputs change on the falling edge; outputs are compared 1 ns later.
// Counter expectations follow HAZARD_STATS_EN (zero when undefined).
module tb_hazard_ctrl;

  localparam logic [3:0] P_NORMAL = 4'b1100;
  localparam logic [3:0] P_STALL  = 4'b0001;
  localparam logic [3:0] P_BRANCH = 4'b1111;
  localparam logic [3:0] P_JUMP   = 4'b1110;
  localparam logic [3:0] P_RESET  = 4'b0011;

  localparam logic [31:0] I_LW8  = 32'h8E08_0000; // lw $8,0($16)
  localparam logic [31:0] I_LW0  = 32'h8E00_0000; // lw $0,0($16)
  localparam logic [31:0] I_ADD  = 32'h010A_4820; // add $9,$8,$10
  localparam logic [31:0] I_ADD0 = 32'h0000_4820; // add $9,$0,$0
  localparam logic [31:0] I_ADDI = 32'h2109_0001; // addi $9,$8,1
  localparam logic [31:0] I_ORI  = 32'h3528_0005; // ori $8,$9,5
  localparam logic [31:0] I_SW   = 32'hAD28_0000; // sw $8,0($9)
  localparam logic [31:0] I_BEQ  = 32'h1128_0000; // beq $9,$8,0

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_ID, inst_EX;
  logic [7:0]  ctrl_EX;
  logic        branch_taken_EX, jump_ID;

  logic        pw1, iw1, if1, ib1, pw3, iw3, if3, ib3;
  logic [31:0] sc1, fc1, sc3, fc3;
  logic [3:0]  o1, o3;

  int total = 0;
  int bad   = 0;

  assign o1 = {pw1, iw1, if1, ib1};
  assign o3 = {pw3, iw3, if3, ib3};

  always #5 clk = ~clk;

  hazard_ctrl #(.LU_STALL_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .inst_ID(inst_ID), .inst_EX(inst_EX), .ctrl_EX(ctrl_EX),
    .branch_taken_EX(branch_taken_EX), .jump_ID(jump_ID),
    .pc_write(pw1), .ifid_write(iw1), .ifid_flush(if1), .idex_bubble(ib1),
    .stall_cnt(sc1), .flush_cnt(fc1)
  );

  hazard_ctrl #(.LU_STALL_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .inst_ID(inst_ID), .inst_EX(inst_EX), .ctrl_EX(ctrl_EX),
    .branch_taken_EX(branch_taken_EX), .jump_ID(jump_ID),
    .pc_write(pw3), .ifid_write(iw3), .ifid_flush(if3), .idex_bubble(ib3),
    .stall_cnt(sc3), .flush_cnt(fc3)
  );

  function automatic logic [31:0] expc(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  task automatic set_idle();
    inst_ID = 32'h0; inst_EX = 32'h0; ctrl_EX = 8'h00;
    branch_taken_EX = 1'b0; jump_ID = 1'b0;
  endtask

  task automatic set_hazard();
    inst_EX = I_LW8; ctrl_EX = 8'h78; inst_ID = I_ADD;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_idle();
    #1;
    total++; if (o1 !== P_RESET) begin bad++; $display("FAIL reset_out1 got=%b exp=%b", o1, P_RESET); end
    total++; if (o3 !== P_RESET) begin bad++; $display("FAIL reset_out3 got=%b exp=%b", o3, P_RESET); end
    @(posedge clk); #1;
    total++; if (sc3 !== 32'd0 || fc3 !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", sc3, fc3); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (o1 !== P_NORMAL) begin bad++; $display("FAIL reset_release got=%b exp=%b", o1, P_NORMAL); end
  endtask

  task automatic test_load_use_1();
    do_reset();
    @(negedge clk); set_hazard(); #1;
    total++; if (o1 !== P_STALL) begin bad++; $display("FAIL lu1_stall got=%b exp=%b", o1, P_STALL); end
    // bubble reaches EX: MemRead cleared, ID instruction held
    @(negedge clk); inst_EX = 32'h0; ctrl_EX = 8'h00; #1;
    total++; if (o1 !== P_NORMAL) begin bad++; $display("FAIL lu1_after got=%b exp=%b", o1, P_NORMAL); end
    total++; if (sc1 !== expc(1)) begin bad++; $display("FAIL lu1_stall_cnt got=%0d exp=%0d", sc1, expc(1)); end
  endtask

  task automatic test_load_use_3();
    do_reset();
    @(negedge clk); set_hazard(); #1;
    total++; if (o3 !== P_STALL) begin bad++; $display("FAIL lu3_cyc0 got=%b exp=%b", o3, P_STALL); end
    for (int c = 1; c < 3; c++) begin
      @(negedge clk); inst_EX = 32'h0; ctrl_EX = 8'h00; #1;
      total++; if (o3 !== P_STALL) begin bad++; $display("FAIL lu3_cyc%0d got=%b exp=%b", c, o3, P_STALL); end
    end
    @(negedge clk); #1;
    total++; if (o3 !== P_NORMAL) begin bad++; $display("FAIL lu3_end got=%b exp=%b", o3, P_NORMAL); end
    total++; if (sc3 !== expc(3)) begin bad++; $display("FAIL lu3_stall_cnt got=%0d exp=%0d", sc3, expc(3)); end
    total++; if (fc3 !== 32'd0) begin bad++; $display("FAIL lu3_flush_cnt got=%0d exp=0", fc3); end
  endtask

  task automatic test_detect();
    logic [31:0] t_ex [7];
    logic [7:0]  t_ct [7];
    logic [31:0] t_id [7];
    logic        t_hit[7];
    t_ex[0] = I_LW0; t_ct[0] = 8'h78; t_id[0] = I_ADD0; t_hit[0] = 1'b0;
    t_ex[1] = I_LW8; t_ct[1] = 8'h78; t_id[1] = I_ADDI; t_hit[1] = 1'b1;
    t_ex[2] = I_LW8; t_ct[2] = 8'h78; t_id[2] = I_ORI;  t_hit[2] = 1'b0;
    t_ex[3] = I_LW8; t_ct[3] = 8'h78; t_id[3] = I_SW;   t_hit[3] = 1'b1;
    t_ex[4] = I_LW8; t_ct[4] = 8'h78; t_id[4] = I_BEQ;  t_hit[4] = 1'b1;
    t_ex[5] = I_LW8; t_ct[5] = 8'h70; t_id[5] = I_ADD;  t_hit[5] = 1'b0;
    t_ex[6] = I_LW8; t_ct[6] = 8'h78; t_id[6] = I_ADD;  t_hit[6] = 1'b1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      inst_EX = t_ex[i]; ctrl_EX = t_ct[i]; inst_ID = t_id[i];
      #1;
      total++;
      if (o1 !== (t_hit[i] ? P_STALL : P_NORMAL)) begin
        bad++; $display("FAIL detect_%0d got=%b exp=%b", i, o1, t_hit[i] ? P_STALL : P_NORMAL);
      end
    end
    @(negedge clk); set_idle();
  endtask

  task automatic test_branch_abort();
    do_reset();
    @(negedge clk); set_hazard(); #1;
    total++; if (o3 !== P_STALL) begin bad++; $display("FAIL br_cyc0 got=%b exp=%b", o3, P_STALL); end
    @(negedge clk); inst_EX = 32'h0; ctrl_EX = 8'h00; branch_taken_EX = 1'b1; #1;
    total++; if (o3 !== P_BRANCH) begin bad++; $display("FAIL br_cyc1 got=%b exp=%b", o3, P_BRANCH); end
    @(negedge clk); branch_taken_EX = 1'b0; #1;
    total++; if (o3 !== P_NORMAL) begin bad++; $display("FAIL br_cyc2 got=%b exp=%b", o3, P_NORMAL); end
    @(negedge clk); #1;
    total++; if (o3 !== P_NORMAL) begin bad++; $display("FAIL br_cyc3 got=%b exp=%b", o3, P_NORMAL); end
    total++; if (sc3 !== expc(1)) begin bad++; $display("FAIL br_stall_cnt got=%0d exp=%0d", sc3, expc(1)); end
    total++; if (fc3 !== expc(1)) begin bad++; $display("FAIL br_flush_cnt got=%0d exp=%0d", fc3, expc(1)); end
  endtask

  task automatic test_jump();
    do_reset();
    @(negedge clk); jump_ID = 1'b1; #1;
    total++; if (o1 !== P_JUMP) begin bad++; $display("FAIL jump got=%b exp=%b", o1, P_JUMP); end
    @(negedge clk); jump_ID = 1'b0; #1;
    total++; if (o1 !== P_NORMAL) begin bad++; $display("FAIL jump_after got=%b exp=%b", o1, P_NORMAL); end
    total++; if (fc1 !== expc(1)) begin bad++; $display("FAIL jump_flush_cnt got=%0d exp=%0d", fc1, expc(1)); end
    // stall outranks jump
    @(negedge clk); jump_ID = 1'b1; set_hazard(); #1;
    total++; if (o1 !== P_STALL) begin bad++; $display("FAIL jump_vs_stall got=%b exp=%b", o1, P_STALL); end
    // branch outranks both
    @(negedge clk); branch_taken_EX = 1'b1; #1;
    total++; if (o1 !== P_BRANCH) begin bad++; $display("FAIL branch_vs_all got=%b exp=%b", o1, P_BRANCH); end
    @(negedge clk); set_idle(); #1;
    total++; if (fc1 !== expc(2)) begin bad++; $display("FAIL prio_flush_cnt got=%0d exp=%0d", fc1, expc(2)); end
    total++; if (sc1 !== expc(1)) begin bad++; $display("FAIL prio_stall_cnt got=%0d exp=%0d", sc1, expc(1)); end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk); set_hazard(); #1;
    total++; if (o3 !== P_STALL) begin bad++; $display("FAIL ar_cyc0 got=%b exp=%b", o3, P_STALL); end
    @(negedge clk); inst_EX = 32'h0; ctrl_EX = 8'h00; #1;
    total++; if (o3 !== P_STALL) begin bad++; $display("FAIL ar_cyc1 got=%b exp=%b", o3, P_STALL); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (o3 !== P_RESET) begin bad++; $display("FAIL ar_pattern got=%b exp=%b", o3, P_RESET); end
    total++; if (sc3 !== 32'd0 || fc3 !== 32'd0) begin bad++; $display("FAIL ar_cnt got=%0d/%0d exp=0/0", sc3, fc3); end
    @(negedge clk); rst_n = 1'b1; #1;
    total++; if (o3 !== P_NORMAL) begin bad++; $display("FAIL ar_release got=%b exp=%b", o3, P_NORMAL); end
    @(negedge clk); #1;
    total++; if (o3 !== P_NORMAL) begin bad++; $display("FAIL ar_run got=%b exp=%b", o3, P_NORMAL); end
    total++; if (sc3 !== 32'd0) begin bad++; $display("FAIL ar_stall_cnt got=%0d exp=0", sc3); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    set_idle();
    test_reset();
    test_load_use_1();
    test_load_use_3();
    test_detect();
    test_branch_abort();
    test_jump();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
